memory_data_register: RTL and testbench



---
 rtl/memory_data_register.sv | 47 ++++
 tb/tb_memory_data_register.sv | 136 +++++++++++++
 2 files changed

// File: rtl/memory_data_register.sv
// Holding register between the memory data bus and the CPU datapath.
// It captures a word on an enabled clock edge and holds it until the next write or a reset.
module memory_data_register #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_q;
  logic                  valid_d;

  // Next-state selection: load on write_enable, otherwise hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (write_enable) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
    end
  end

  // State register; the synchronous reset overrides a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VALUE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_memory_data_register.sv
// Directed self-checking bench for memory_data_register.
// It steps through reset, load/hold, overwrite, reset priority, back-to-back writes and a mid-cycle reset pulse.
module tb_memory_data_register;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;
  logic        data_valid;

  int tests_run;
  int tests_failed;

  memory_data_register #(
    .DATA_WIDTH (32),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .write_enable(write_enable),
    .data_out    (data_out),
    .data_valid  (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    reset        = 1'b1;
    write_enable = 1'b0;
    data_in      = 32'hDEAD_BEEF;
    tick();
    check("reset_data", data_out, 32'h0000_0000);
    check("reset_valid", {31'd0, data_valid}, 32'd0);

    reset = 1'b0;
    tick();
    check("post_reset_idle_data", data_out, 32'h0000_0000);
    check("post_reset_idle_valid", {31'd0, data_valid}, 32'd0);

    write_enable = 1'b1;
    data_in      = 32'hDEAD_BEEF;
    tick();
    check("load_data", data_out, 32'hDEAD_BEEF);
    check("load_valid", {31'd0, data_valid}, 32'd1);

    write_enable = 1'b0;
    tick();
    check("hold1_data", data_out, 32'hDEAD_BEEF);
    tick();
    check("hold2_data", data_out, 32'hDEAD_BEEF);
    check("hold2_valid", {31'd0, data_valid}, 32'd1);

    write_enable = 1'b1;
    data_in      = 32'hCAFE_BABE;
    tick();
    check("overwrite_data", data_out, 32'hCAFE_BABE);

    write_enable = 1'b0;
    data_in      = 32'h1234_5678;
    tick();
    check("ignore_din1", data_out, 32'hCAFE_BABE);
    tick();
    check("ignore_din2", data_out, 32'hCAFE_BABE);

    reset = 1'b1;
    tick();
    check("reset_hold_data", data_out, 32'h0000_0000);
    check("reset_hold_valid", {31'd0, data_valid}, 32'd0);

    reset = 1'b0;
    tick();
    check("after_reset1_data", data_out, 32'h0000_0000);
    tick();
    check("after_reset2_data", data_out, 32'h0000_0000);
    check("after_reset2_valid", {31'd0, data_valid}, 32'd0);

    reset        = 1'b1;
    write_enable = 1'b1;
    data_in      = 32'hA5A5_A5A5;
    tick();
    check("reset_priority_data", data_out, 32'h0000_0000);
    check("reset_priority_valid", {31'd0, data_valid}, 32'd0);

    reset = 1'b0;
    tick();
    check("first_edge_load_data", data_out, 32'hA5A5_A5A5);
    check("first_edge_load_valid", {31'd0, data_valid}, 32'd1);

    data_in = 32'h0000_0001;
    tick();
    check("b2b_1", data_out, 32'h0000_0001);
    data_in = 32'h0000_0002;
    tick();
    check("b2b_2", data_out, 32'h0000_0002);
    data_in = 32'h0000_0003;
    tick();
    check("b2b_3", data_out, 32'h0000_0003);

    // Reset pulse confined between two rising edges must be invisible.
    write_enable = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_pulse_data", data_out, 32'h0000_0003);
    #1;
    reset = 1'b0;
    tick();
    check("after_pulse_data", data_out, 32'h0000_0003);
    check("after_pulse_valid", {31'd0, data_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
